data_n_to_1_pipe: RTL and testbench
===================================

Name: data_n_to_1_pipe

Overview:
- Parametrised, registered N-to-1 data selector for the CPU datapath, generalising the plain 2-to-1 operand mux.
- Selects one of NUM words of WIDTH bits and registers the result into a one-stage output pipeline.
- Uses a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, and a synchronous flush for branch/exception squash.
- Sits between the operand/forwarding sources and the consuming pipeline stage (ALU or memory address path).

Parameters:
- WIDTH, 32, bits per data word.
- NUM, 4, number of selectable inputs; legal range 2 to 16.
- SEL_W, $clog2(NUM), select width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NUM*WIDTH  flattened inputs; word i occupies bits [i*WIDTH +: WIDTH].
- in_sel  input  SEL_W  index of the selected word.
- in_valid  input  1  producer offers in_data/in_sel.
- in_ready  output  1  block can accept; driven directly from a register.
- flush  input  1  synchronous squash of all held entries.
- out_data  output  WIDTH  selected word, registered.
- out_sel  output  SEL_W  in_sel captured with out_data.
- out_err  output  1  captured in_sel was >= NUM; out_data is 0 for that entry.
- out_valid  output  1  out_data/out_sel/out_err are valid.
- out_ready  input  1  consumer accepts.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous, active-high.
- Reset state: out_valid=0, out_data=0, out_sel=0, out_err=0, skid entry empty and zeroed, in_ready=1. in_ready is asserted while rst is high.
- Selection: word = in_data[in_sel*WIDTH +: WIDTH] when in_sel < NUM. Otherwise word = 0 and err = 1.
- Accept and deliver:
  - Accept occurs when in_valid && in_ready at a rising edge.
  - Deliver occurs when out_valid && out_ready at a rising edge.
- Latency: an accepted word appears on out_* the next cycle when the output register is free.
- Storage: main register (drives out_*) plus one skid register. in_ready = !skid_valid.
- Per-edge cases (flush=0):
  - Accept, main empty or delivering: load the new entry into main.
  - Accept, main full and not delivering: load the new entry into skid.
  - Deliver, skid full: move skid to main and clear skid_valid.
  - Deliver, skid empty, no accept: clear out_valid.
  - Simultaneous accept and deliver with skid empty: main takes the new entry. Throughput is 1 word per cycle.
  - skid_valid=1 implies in_ready=0, so no accept occurs while skid is full.
- Ordering: entries leave strictly in accept order.
- Hold rule: while out_valid && !out_ready, out_data, out_sel and out_err hold stable.
- Flush:
  - Next edge: out_valid=0 and skid_valid=0; in_ready=1 the following cycle.
  - An accept in the flush cycle is discarded.
  - Flush has priority over every other event.
  - Data registers need not clear on flush.
- Reset mid-operation: all entries are dropped immediately (asynchronous), returning to the reset state. No partial transfer.
- No combinational path from in_* or out_ready to any output.

Test Plan:
- Reset then stream: WIDTH=32, NUM=4, in_data words {0x11111111, 0x22222222, 0x33333333, 0x44444444}, in_sel sequence 0,1,2,3 with in_valid=1 and out_ready=1 held high -> out_data 0x11111111..0x44444444 on 4 consecutive cycles starting 1 cycle after the first accept; in_ready stays 1.
- Back-pressure: out_ready=0 while sending sel=2 then sel=3 -> out_data holds 0x33333333, skid holds 0x44444444, in_ready=0 from the second cycle. Raise out_ready -> 0x33333333 then 0x44444444 delivered; in_ready returns to 1.
- Out-of-range: NUM=3, in_sel=3 -> out_data=0, out_err=1, out_sel=3; next entry with sel=1 -> out_err=0.
- Flush: main and skid full, assert flush for 1 cycle together with in_valid=1 -> out_valid=0 and in_ready=1 next cycle; neither the held words nor the offered word ever appear on out_*.
- Async reset: assert rst mid-stream between clock edges -> out_valid=0 and in_ready=1 immediately, before the next edge; after release, the first accepted word appears 1 cycle later.
- Random handshake: 1000 cycles of random in_valid and out_ready against a scoreboard FIFO -> no loss, no duplication, in-order delivery, output held stable under stall.

Source files
------------

// File: rtl/data_n_to_1_pipe.sv
// Registered N-to-1 word selector with a valid/ready handshake, 2-entry skid
// buffering and a synchronous flush for the CPU operand path.
module data_n_to_1_pipe #(
  parameter  int WIDTH = 32,
  parameter  int NUM   = 4,
  localparam int SEL_W = $clog2(NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] sel_word;
  logic             sel_err;

  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_sel;
  logic             skid_err;
  logic             skid_valid;

  logic [WIDTH-1:0] out_data_nxt, skid_data_nxt;
  logic [SEL_W-1:0] out_sel_nxt, skid_sel_nxt;
  logic             out_err_nxt, skid_err_nxt;
  logic             out_valid_nxt, skid_valid_nxt;

  logic accept;
  logic main_free;

  // Indices at or above NUM fall through the loop and leave word=0, err=1.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sel_word = '0;
    sel_err  = 1'b1;
    for (int i = 0; i < NUM; i++) begin
      if (in_sel == SEL_W'(i)) begin
        sel_word = in_data[i*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign accept    = in_valid && in_ready;
  assign main_free = !out_valid || out_ready;

  always_comb begin
    out_data_nxt   = out_data;
    out_sel_nxt    = out_sel;
    out_err_nxt    = out_err;
    out_valid_nxt  = out_valid;
    skid_data_nxt  = skid_data;
    skid_sel_nxt   = skid_sel;
    skid_err_nxt   = skid_err;
    skid_valid_nxt = skid_valid;

    if (flush) begin
      out_valid_nxt  = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (main_free) begin
      // A full skid always holds the older word, so it refills main first;
      // in_ready is low then, so no accept can compete with it.
      if (skid_valid) begin
        out_data_nxt   = skid_data;
        out_sel_nxt    = skid_sel;
        out_err_nxt    = skid_err;
        out_valid_nxt  = 1'b1;
        skid_valid_nxt = 1'b0;
      end else if (accept) begin
        out_data_nxt  = sel_word;
        out_sel_nxt   = in_sel;
        out_err_nxt   = sel_err;
        out_valid_nxt = 1'b1;
      end else begin
        out_valid_nxt = 1'b0;
      end
    end else if (accept) begin
      skid_data_nxt  = sel_word;
      skid_sel_nxt   = in_sel;
      skid_err_nxt   = sel_err;
      skid_valid_nxt = 1'b1;
    end
  end

  // in_ready is its own flop holding the inverse of the next skid state, so
  // it carries no combinational path from the handshake inputs.
  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data   <= '0;
      out_sel    <= '0;
      out_err    <= 1'b0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_sel   <= '0;
      skid_err   <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      out_data   <= out_data_nxt;
      out_sel    <= out_sel_nxt;
      out_err    <= out_err_nxt;
      out_valid  <= out_valid_nxt;
      skid_data  <= skid_data_nxt;
      skid_sel   <= skid_sel_nxt;
      skid_err   <= skid_err_nxt;
      skid_valid <= skid_valid_nxt;
      in_ready   <= !skid_valid_nxt;
    end
  end

endmodule

// File: tb/tb_data_n_to_1_pipe.sv
// Directed and random-handshake bench for data_n_to_1_pipe (NUM=4 instance
// plus a NUM=3 instance for out-of-range selects).
module tb_data_n_to_1_pipe;

  logic         clk;
  logic         rst;
  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_err;
  logic         out_valid;
  logic         out_ready;

  logic [95:0]  in_data3;
  logic [1:0]   in_sel3;
  logic         in_valid3;
  logic         in_ready3;
  logic         flush3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;
  logic         out_err3;
  logic         out_valid3;
  logic         out_ready3;

  int n_assert = 0;
  int n_fail   = 0;

  data_n_to_1_pipe #(.WIDTH(32), .NUM(4)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_sel(out_sel), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  data_n_to_1_pipe #(.WIDTH(32), .NUM(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_sel(in_sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
    .out_data(out_data3), .out_sel(out_sel3), .out_err(out_err3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] w [4];
  logic [33:0] sb [$];
  logic [33:0] held;
  logic        held_flag;
  logic        acc, del;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sel = '0;
    in_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    in_data3 = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    in_sel3 = '0; in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b1;

    // Reset state
    #3;
    check("rst_in_ready",  64'(in_ready),  64'h1);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data",  64'(out_data),  64'h0);
    check("rst_out_sel",   64'(out_sel),   64'h0);
    check("rst_out_err",   64'(out_err),   64'h0);
    tick(); tick();
    rst = 1'b0;

    // Stream 0..3 at full throughput
    in_valid = 1'b1; out_ready = 1'b1; in_sel = 2'd0;
    tick();
    check("stream0_valid", 64'(out_valid), 64'h1);
    check("stream0_data",  64'(out_data),  64'h1111_1111);
    in_sel = 2'd1;
    tick();
    check("stream1_data",  64'(out_data),  64'h2222_2222);
    in_sel = 2'd2;
    tick();
    check("stream2_data",  64'(out_data),  64'h3333_3333);
    in_sel = 2'd3;
    tick();
    check("stream3_data",  64'(out_data),  64'h4444_4444);
    check("stream3_sel",   64'(out_sel),   64'h3);
    check("stream_ready",  64'(in_ready),  64'h1);
    in_valid = 1'b0;
    tick();
    check("stream_drain",  64'(out_valid), 64'h0);

    // Back-pressure into the skid
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd2;
    tick();
    check("bp_main",       64'(out_data),  64'h3333_3333);
    check("bp_ready1",     64'(in_ready),  64'h1);
    in_sel = 2'd3;
    tick();
    check("bp_ready0",     64'(in_ready),  64'h0);
    check("bp_hold1",      64'(out_data),  64'h3333_3333);
    in_valid = 1'b0;
    tick();
    check("bp_hold2",      64'(out_data),  64'h3333_3333);
    check("bp_hold_valid", 64'(out_valid), 64'h1);
    out_ready = 1'b1;
    tick();
    check("bp_skid_out",   64'(out_data),  64'h4444_4444);
    check("bp_ready_back", 64'(in_ready),  64'h1);
    tick();
    check("bp_empty",      64'(out_valid), 64'h0);

    // Out-of-range select on the NUM=3 instance
    in_valid3 = 1'b1; in_sel3 = 2'd3;
    tick();
    check("oor_valid",     64'(out_valid3), 64'h1);
    check("oor_data",      64'(out_data3),  64'h0);
    check("oor_err",       64'(out_err3),   64'h1);
    check("oor_sel",       64'(out_sel3),   64'h3);
    in_sel3 = 2'd1;
    tick();
    check("inr_data",      64'(out_data3),  64'hBBBB_BBBB);
    check("inr_err",       64'(out_err3),   64'h0);
    check("inr_sel",       64'(out_sel3),   64'h1);
    in_valid3 = 1'b0;
    tick();

    // Flush with main and skid full
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
    tick();
    in_sel = 2'd1;
    tick();
    check("fl_full_ready", 64'(in_ready),  64'h0);
    in_sel = 2'd2; flush = 1'b1;
    tick();
    check("fl_valid",      64'(out_valid), 64'h0);
    check("fl_ready",      64'(in_ready),  64'h1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("fl_after1",     64'(out_valid), 64'h0);
    tick();
    check("fl_after2",     64'(out_valid), 64'h0);

    // Flush discards an accept made in the same cycle
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd3;
    tick();
    in_sel = 2'd2; flush = 1'b1;
    check("fl2_ready_pre", 64'(in_ready),  64'h1);
    tick();
    check("fl2_valid",     64'(out_valid), 64'h0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("fl2_after",     64'(out_valid), 64'h0);

    // Asynchronous reset between edges
    in_valid = 1'b1; in_sel = 2'd0;
    tick();
    out_ready = 1'b0; in_sel = 2'd1;
    tick();
    check("ar_pre_ready",  64'(in_ready),  64'h0);
    #2 rst = 1'b1;
    #1;
    check("ar_valid",      64'(out_valid), 64'h0);
    check("ar_ready",      64'(in_ready),  64'h1);
    check("ar_data",       64'(out_data),  64'h0);
    #2 rst = 1'b0;
    in_valid = 1'b1; in_sel = 2'd2; out_ready = 1'b1;
    tick();
    check("ar_first_val",  64'(out_valid), 64'h1);
    check("ar_first_data", 64'(out_data),  64'h3333_3333);
    in_valid = 1'b0;
    tick();

    // Random handshake against a scoreboard
    held_flag = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      for (int k = 0; k < 4; k++) w[k] = $urandom;
      in_data   = {w[3], w[2], w[1], w[0]};
      in_sel    = 2'($urandom_range(0, 3));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) begin
        if (sb.size() == 0) check("rnd_extra", 64'(out_data), 64'h1_0000_0000);
        else check("rnd_deliver", 64'({out_sel, out_data}), 64'(sb.pop_front()));
      end
      if (acc) sb.push_back({in_sel, w[in_sel]});
      held_flag = out_valid && !out_ready;
      held = {out_sel, out_data};
      tick();
      if (held_flag) check("rnd_hold", 64'({out_valid, out_sel, out_data}), 64'({1'b1, held}));
    end

    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) begin
        if (sb.size() == 0) check("drain_extra", 64'(out_data), 64'h1_0000_0000);
        else check("drain_deliver", 64'({out_sel, out_data}), 64'(sb.pop_front()));
      end
      tick();
    end
    check("sb_empty", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
